// File: rtl/res_writeback.sv
// res_writeback: saturates signed accumulator results to bytes, packs four per 32-bit word, writes words to memory.
// Latency: the word is presented on mem_* the cycle after lane 3 (or a flush) is accepted; back-to-back words have no bubble.
// Backpressure: mem_wr_en/mem_adr/mem_wdata are held until mem_ack; res_ready drops only when a full packed word waits behind a pending write.
//
// Ports:
//   clk, rst              sole clock (rising edge), asynchronous active-high reset
//   start, base_adr       run start (honoured in IDLE only) and first word address
//   res_valid, res_data   one-cycle result strobe and signed result (DATA_W bits)
//   res_ready             result can be accepted this cycle
//   flush                 write out a partially packed word (zero padded)
//   mem_wr_en, mem_adr,   write request, word address, packed data;
//   mem_wdata, mem_ack    held stable until mem_ack
//   word_count            words acknowledged this run
//   busy, done            high in COLLECT/WRITE; one-cycle end-of-run pulse
module res_writeback #(
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 43
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        base_adr,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              flush,
  input  logic              mem_ack,
  output logic              res_ready,
  output logic              mem_wr_en,
  output logic [7:0]        mem_adr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        word_count,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] NUM_W8 = 8'(NUM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_pack;      // lanes above r_lane are always zero, so flush padding is free
  logic [2:0]  r_lane;      // 0..4; 4 only while a full word waits behind a pending write
  logic        r_wr_en;
  logic [7:0]  r_adr;
  logic [31:0] r_wdata;
  logic [7:0]  r_word_count;

  logic [7:0]  w_byte;
  logic        w_acc;
  logic [2:0]  w_lane_nxt;
  logic [31:0] w_pack_nxt;
  logic        w_full;
  logic        w_flush;
  logic        w_ack;
  logic        w_last;

  // Saturate the signed result into 0..255.
  always_comb begin
    w_byte = res_data[7:0];
    if (res_data[DATA_W-1])
      w_byte = 8'd0;
    else if (|res_data[DATA_W-2:8])
      w_byte = 8'd255;
  end

  assign res_ready = ((r_state == S_COLLECT) || (r_state == S_WRITE)) &&
                     !((r_lane == 3'd4) && r_wr_en);
  assign w_acc      = res_valid && res_ready;
  assign w_lane_nxt = r_lane + {2'b00, w_acc};

  always_comb begin
    w_pack_nxt = r_pack;
    if (w_acc) begin
      case (r_lane[1:0])
        2'd0:    w_pack_nxt[7:0]   = w_byte;
        2'd1:    w_pack_nxt[15:8]  = w_byte;
        2'd2:    w_pack_nxt[23:16] = w_byte;
        default: w_pack_nxt[31:24] = w_byte;
      endcase
    end
  end

  // Flush sees the lane count after this cycle's accept, so a same-cycle result is included.
  assign w_full  = (w_lane_nxt == 3'd4);
  assign w_flush = flush && (r_state == S_COLLECT) && (w_lane_nxt != 3'd0);
  assign w_ack   = mem_ack && r_wr_en;
  assign w_last  = ((r_word_count + 8'd1) == NUM_W8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pack       <= 32'd0;
      r_lane       <= 3'd0;
      r_wr_en      <= 1'b0;
      r_adr        <= 8'd0;
      r_wdata      <= 32'd0;
      r_word_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_COLLECT;
            r_adr        <= base_adr;
            r_word_count <= 8'd0;
            r_lane       <= 3'd0;
            r_pack       <= 32'd0;
          end
        end
        S_COLLECT: begin
          if (w_full || w_flush) begin
            r_wdata <= w_pack_nxt;
            r_wr_en <= 1'b1;
            r_pack  <= 32'd0;
            r_lane  <= 3'd0;
            r_state <= S_WRITE;
          end else begin
            r_pack <= w_pack_nxt;
            r_lane <= w_lane_nxt;
          end
        end
        S_WRITE: begin
          if (w_ack) begin
            r_adr        <= r_adr + 8'd1;
            r_word_count <= r_word_count + 8'd1;
            if (w_last) begin
              // Run complete: any partially packed lanes are discarded.
              r_wr_en <= 1'b0;
              r_pack  <= 32'd0;
              r_lane  <= 3'd0;
              r_state <= S_DONE;
            end else if (w_full) begin
              // Next word is ready: reload without dropping mem_wr_en.
              r_wdata <= w_pack_nxt;
              r_pack  <= 32'd0;
              r_lane  <= 3'd0;
            end else begin
              r_wr_en <= 1'b0;
              r_pack  <= w_pack_nxt;
              r_lane  <= w_lane_nxt;
              r_state <= S_COLLECT;
            end
          end else begin
            r_pack <= w_pack_nxt;
            r_lane <= w_lane_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_wr_en  = r_wr_en;
  assign mem_adr    = r_adr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_word_count;
  assign busy       = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);

endmodule

// File: doc/res_writeback.md
RES_WRITEBACK -- requirements
Module: res_writeback

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, accumulator result width (signed).
REQ-002 The block SHALL have parameter NUM_WORDS, default 43, number of 32-bit words written per run.
REQ-003 The block SHALL have one clock and one reset: clk  input  1  sole clock, rising edge; rst  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  run-start pulse, honoured only in IDLE.
REQ-005 Port base_adr  input  8  first memory word address, sampled with start.
REQ-006 Port res_valid  input  1  one-cycle strobe for res_data.
REQ-007 Port res_data  input  DATA_W  signed accumulator result.
REQ-008 Port flush  input  1  force write of a partially packed word.
REQ-009 Port mem_ack  input  1  memory accepted the current write.
REQ-010 Port res_ready  output  1  block can accept res_valid this cycle.
REQ-011 Port mem_wr_en  output  1  write request, held until acknowledged.
REQ-012 Port mem_adr  output  8  write word address.
REQ-013 Port mem_wdata  output  32  packed write word.
REQ-014 Port word_count  output  8  words acknowledged this run.
REQ-015 Port busy  output  1  high in COLLECT or WRITE.
REQ-016 Port done  output  1  one-cycle end-of-run pulse.

Function
REQ-017 FSM states SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: start=1 -> COLLECT next edge; mem_adr<=base_adr, word_count<=0, lane count<=0; start in other states ignored.
REQ-019 Conversion SHALL be: res_data<0 -> 8'd0; res_data>255 -> 8'd255; else res_data[7:0].
REQ-020 Accepted results SHALL pack lane 0 first into mem_wdata[7:0], lane 3 into [31:24].
REQ-021 A result SHALL be accepted only when res_valid & res_ready; res_valid otherwise ignored.
REQ-022 res_ready SHALL be 1 in COLLECT and WRITE, except 0 when the pack register is full (4 lanes) and a write is pending; 0 in IDLE and DONE.
REQ-023 On the edge accepting lane 3 with no write pending: word loads into the write register, lane count<=0, state->WRITE, mem_wr_en=1 from the next cycle.
REQ-024 In WRITE, mem_wr_en, mem_adr, mem_wdata SHALL stay stable until mem_ack=1 is sampled; mem_ack while mem_wr_en=0 ignored.
REQ-025 On the ack edge: mem_adr+1 (wraps 255->0), word_count+1; if a full packed word waits (or lane 3 is accepted on the same edge) it loads into the write register with no bubble and state stays WRITE; otherwise state->COLLECT.
REQ-026 flush=1 in COLLECT with lane count 1..3 SHALL pad remaining lanes with 0 and issue the write as REQ-023; flush with lane count 0 or during WRITE SHALL be ignored.
REQ-027 res_valid and flush on the same cycle: result accepted first, flush applied to the updated lane count.
REQ-028 When the ack makes word_count reach NUM_WORDS: state->DONE, done=1 for exactly one cycle, then IDLE; unsent lanes discarded.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and drive res_ready, mem_wr_en, busy, done to 0 and mem_adr, mem_wdata, word_count, lane count to 0.
REQ-030 Reset mid-write SHALL drop the pending and packed words; no write follows release.

Verification
REQ-031 start, base_adr=8'h10; results 5,300,-7,255; mem_ack after 2 cycles -> mem_wdata=32'hFF00FF05 at adr 8'h10, held 2 cycles, then adr 8'h11, word_count=1.
REQ-032 Ack withheld, 4 more results -> res_ready=0 after 4th; ack -> second word issued next cycle without mem_wr_en dropping, res_ready=1.
REQ-033 Two results 1,2 then flush -> mem_wdata=32'h00000201; flush with zero lanes -> no write.
REQ-034 NUM_WORDS=2, 8 results, immediate acks -> done pulses once after 2nd ack, word_count=2, then IDLE, res_ready=0.
REQ-035 rst asserted while mem_wr_en=1 -> all outputs 0 asynchronously, no write after release, new start works.
